// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: opcodes, control states and the flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic overflow;
    logic unsigned_overflow;
    logic is_zero;
    logic sign;
  } alu_flags_t;

endpackage

// File: rtl/iter_multiplier.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH steps per operation.
module iter_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_next_s;

  // Accumulator value after the current step; on the last step this is the full product.
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  assign done    = (count_r == CW'(1));
  assign product = acc_next_s;

  // Operand capture on start, then one shift-add step per cycle until the counter drains.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_r  <= '0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else if (start) begin
      count_r  <= CW'(WIDTH);
      acc_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, op_a};
      mplier_r <= op_b;
    end else if (count_r != '0) begin
      count_r  <= count_r - CW'(1);
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end else begin
      count_r  <= count_r;
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/shift, iterative multiply, results held until accepted.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startValid,
  output logic             startReady,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] firstArg,
  input  logic [WIDTH-1:0] secondArg,
  output logic             resultValid,
  input  logic             resultReady,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             unsignedOverflow,
  output logic             isZero,
  output logic             sign
);

  localparam int   SW     = $clog2(WIDTH);
  localparam int   MSB    = WIDTH - 1;
  localparam logic MUL_ON = MUL_EN;

  alu_state_e         state_r, state_next_s;
  logic [WIDTH-1:0]   result_r, result_next_s;
  alu_flags_t         flags_r, flags_next_s;
  logic               valid_r;
  logic               accept_s;
  opcode_e            op_s;
  logic [SW-1:0]      amt_s;
  logic [WIDTH:0]     sum_s, diff_s;
  logic [2*WIDTH-1:0] shl_s, shr_s;
  logic [WIDTH-1:0]   op_result_s;
  logic               op_ovf_s, op_uovf_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  function automatic alu_flags_t make_flags(input logic ovf, input logic uovf,
                                            input logic [WIDTH-1:0] res);
    alu_flags_t f;
    f.overflow          = ovf;
    f.unsigned_overflow = uovf;
    f.is_zero           = (res == '0);
    f.sign              = res[MSB];
    return f;
  endfunction

  assign op_s       = opcode_e'(opcode);
  assign amt_s      = secondArg[SW-1:0];
  assign startReady = (state_r == S_IDLE);
  assign accept_s   = startValid && (state_r == S_IDLE);

  generate
    if (MUL_EN) begin : g_mul
      iter_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .resetN  (resetN),
        .start   (accept_s && (op_s == OP_MUL)),
        .op_a    (firstArg),
        .op_b    (secondArg),
        .done    (mul_done_s),
        .product (mul_prod_s)
      );
    end else begin : g_no_mul
      assign mul_done_s = 1'b0;
      assign mul_prod_s = '0;
    end
  endgenerate

  // Single-cycle datapath; an unimplemented MUL falls to the zero default.
  always_comb begin
    op_result_s = '0;
    op_ovf_s    = 1'b0;
    op_uovf_s   = 1'b0;
    sum_s       = {1'b0, firstArg} + {1'b0, secondArg};
    diff_s      = {1'b0, firstArg} - {1'b0, secondArg};
    shl_s       = {{WIDTH{1'b0}}, firstArg} << amt_s;
    shr_s       = {firstArg, {WIDTH{1'b0}}} >> amt_s;
    case (op_s)
      OP_ADD: begin
        op_result_s = sum_s[WIDTH-1:0];
        op_uovf_s   = sum_s[WIDTH];
        op_ovf_s    = (firstArg[MSB] == secondArg[MSB]) && (sum_s[MSB] != firstArg[MSB]);
      end
      OP_SUB: begin
        op_result_s = diff_s[WIDTH-1:0];
        op_uovf_s   = diff_s[WIDTH];
        op_ovf_s    = (firstArg[MSB] != secondArg[MSB]) && (diff_s[MSB] != firstArg[MSB]);
      end
      OP_AND: op_result_s = firstArg & secondArg;
      OP_OR:  op_result_s = firstArg | secondArg;
      OP_XOR: op_result_s = firstArg ^ secondArg;
      OP_SHL: begin
        op_result_s = shl_s[WIDTH-1:0];
        op_uovf_s   = |shl_s[2*WIDTH-1:WIDTH];
      end
      OP_SHR: begin
        op_result_s = shr_s[2*WIDTH-1:WIDTH];
        op_uovf_s   = |shr_s[WIDTH-1:0];
      end
      default: begin
        op_result_s = '0;
        op_ovf_s    = 1'b0;
        op_uovf_s   = 1'b0;
      end
    endcase
  end

  // Control: flags are only recomputed when a new result is loaded, so they hold through DONE.
  always_comb begin
    state_next_s  = state_r;
    result_next_s = result_r;
    flags_next_s  = flags_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && (op_s == OP_MUL) && MUL_ON) begin
          state_next_s = S_BUSY;
        end else if (accept_s) begin
          state_next_s  = S_DONE;
          result_next_s = op_result_s;
          flags_next_s  = make_flags(op_ovf_s, op_uovf_s, op_result_s);
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mul_done_s) begin
          state_next_s  = S_DONE;
          result_next_s = mul_prod_s[WIDTH-1:0];
          flags_next_s  = make_flags(|mul_prod_s[2*WIDTH-1:WIDTH],
                                     |mul_prod_s[2*WIDTH-1:WIDTH],
                                     mul_prod_s[WIDTH-1:0]);
        end else begin
          state_next_s = S_BUSY;
        end
      end
      S_DONE: begin
        if (resultReady) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DONE;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, result and flag registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r  <= S_IDLE;
      result_r <= '0;
      flags_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      result_r <= result_next_s;
      flags_r  <= flags_next_s;
      valid_r  <= (state_next_s == S_DONE);
    end
  end

  assign resultValid      = valid_r;
  assign result           = result_r;
  assign overflow         = flags_r.overflow;
  assign unsignedOverflow = flags_r.unsigned_overflow;
  assign isZero           = flags_r.is_zero;
  assign sign             = flags_r.sign;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: vector table on an 8-bit multiply-capable instance plus
// hand sequences for stall, reset abort and a 16-bit instance without multiply.
module tb_iter_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN, startValid, startReady, resultValid, resultReady;
  logic [2:0] opcode;
  logic [7:0] firstArg, secondArg, result;
  logic       overflow, unsignedOverflow, isZero, sign;

  logic        startValid2, startReady2, resultValid2, resultReady2;
  logic [2:0]  opcode2;
  logic [15:0] firstArg2, secondArg2, result2;
  logic        overflow2, unsignedOverflow2, isZero2, sign2;

  int checks   = 0;
  int failures = 0;

  iter_alu #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .resetN(resetN), .startValid(startValid), .startReady(startReady),
    .opcode(opcode), .firstArg(firstArg), .secondArg(secondArg),
    .resultValid(resultValid), .resultReady(resultReady), .result(result),
    .overflow(overflow), .unsignedOverflow(unsignedOverflow), .isZero(isZero), .sign(sign)
  );

  iter_alu #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
    .clk(clk), .resetN(resetN), .startValid(startValid2), .startReady(startReady2),
    .opcode(opcode2), .firstArg(firstArg2), .secondArg(secondArg2),
    .resultValid(resultValid2), .resultReady(resultReady2), .result(result2),
    .overflow(overflow2), .unsignedOverflow(unsignedOverflow2), .isZero(isZero2), .sign(sign2)
  );

  typedef struct {
    opcode_e    op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ovf;
    logic       uovf;
    logic       zero;
    logic       sgn;
    int         vedge;   // edge index where resultValid rises, 0 = the accept edge
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op on the 8-bit instance, scribbling on the inputs while it is busy.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int vedge);
    int guard = 0;
    while (!startReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_issue", startReady, 1);
    opcode = op; firstArg = a; secondArg = b; startValid = 1'b1;
    @(negedge clk);
    vedge = 0;
    while (!resultValid && vedge < 40) begin
      check("busy_start_ready", startReady, 0);
      firstArg = firstArg ^ 8'h5A;
      secondArg = secondArg + 8'd3;
      opcode = 3'd0;
      @(negedge clk);
      vedge++;
    end
    startValid = 1'b0;
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic ovf, input logic uovf,
                       input logic zero, input logic sgn);
    check("w16_ready_before", startReady2, 1);
    opcode2 = op; firstArg2 = a; secondArg2 = b; startValid2 = 1'b1;
    @(negedge clk);
    startValid2 = 1'b0;
    check("w16_valid_1cycle", resultValid2, 1);
    check("w16_result", result2, res);
    check("w16_ovf", overflow2, ovf);
    check("w16_uovf", unsignedOverflow2, uovf);
    check("w16_zero", isZero2, zero);
    check("w16_sign", sign2, sgn);
    @(negedge clk);
    check("w16_ready_after", startReady2, 1);
    check("w16_valid_cleared", resultValid2, 0);
  endtask

  initial begin
    int ve;
    vecs[0]  = '{OP_ADD, 8'd5,   8'd25,  8'd30,  1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{OP_SUB, 8'd5,   8'd25,  8'hEC,  1'b0, 1'b1, 1'b0, 1'b1, 0};
    vecs[2]  = '{OP_ADD, 8'h7F,  8'h01,  8'h80,  1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecs[3]  = '{OP_ADD, 8'hFF,  8'h01,  8'h00,  1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[4]  = '{OP_SHL, 8'h81,  8'd1,   8'h02,  1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[5]  = '{OP_SHR, 8'h81,  8'd9,   8'h40,  1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[6]  = '{OP_AND, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{OP_OR,  8'hF0,  8'h0F,  8'hFF,  1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[8]  = '{OP_XOR, 8'hAA,  8'hAA,  8'h00,  1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[9]  = '{OP_SUB, 8'h80,  8'h01,  8'h7F,  1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{OP_SHL, 8'h81,  8'd0,   8'h81,  1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[11] = '{OP_SHR, 8'h01,  8'd1,   8'h00,  1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[12] = '{OP_MUL, 8'h10,  8'h10,  8'h00,  1'b1, 1'b1, 1'b1, 1'b0, 8};
    vecs[13] = '{OP_MUL, 8'd3,   8'd5,   8'h0F,  1'b0, 1'b0, 1'b0, 1'b0, 8};
    vecs[14] = '{OP_MUL, 8'hFF,  8'hFF,  8'h01,  1'b1, 1'b1, 1'b0, 1'b0, 8};
    vecs[15] = '{OP_MUL, 8'h00,  8'h55,  8'h00,  1'b0, 1'b0, 1'b1, 1'b0, 8};

    resetN = 1'b0; startValid = 1'b0; resultReady = 1'b1;
    opcode = 3'd0; firstArg = 8'd0; secondArg = 8'd0;
    startValid2 = 1'b0; resultReady2 = 1'b1;
    opcode2 = 3'd0; firstArg2 = 16'd0; secondArg2 = 16'd0;
    #12;
    check("rst_valid", resultValid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {overflow, unsignedOverflow, isZero, sign}, 0);
    check("rst_w16_valid", resultValid2, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("rst_start_ready", startReady, 1);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, ve);
      check($sformatf("v%0d_valid_edge", i), ve, vecs[i].vedge);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
      check($sformatf("v%0d_uovf", i), unsignedOverflow, vecs[i].uovf);
      check($sformatf("v%0d_zero", i), isZero, vecs[i].zero);
      check($sformatf("v%0d_sign", i), sign, vecs[i].sgn);
      @(negedge clk);
      check($sformatf("v%0d_ready_after", i), startReady, 1);
      check($sformatf("v%0d_valid_cleared", i), resultValid, 0);
    end

    // Consumer stall: result and flags must hold until resultReady.
    resultReady = 1'b0;
    run_op(OP_MUL, 8'd13, 8'd11, ve);
    check("stall_valid_edge", ve, 8);
    check("stall_result", result, 8'h8F);
    check("stall_flags", {overflow, unsignedOverflow, isZero, sign}, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid_held", resultValid, 1);
      check("stall_result_held", result, 8'h8F);
      check("stall_sign_held", sign, 1);
      check("stall_start_ready_low", startReady, 0);
    end
    resultReady = 1'b1;
    @(negedge clk);
    check("stall_release_valid", resultValid, 0);
    check("stall_release_ready", startReady, 1);

    // Reset during a multiply loses the pending result.
    opcode = 3'd7; firstArg = 8'd13; secondArg = 8'd11; startValid = 1'b1;
    @(negedge clk);
    startValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("abort_valid", resultValid, 0);
    check("abort_result", result, 0);
    check("abort_flags", {overflow, unsignedOverflow, isZero, sign}, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("abort_start_ready", startReady, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_no_late_result", resultValid, 0);
    end
    run_op(OP_ADD, 8'd1, 8'd1, ve);
    check("post_abort_edge", ve, 0);
    check("post_abort_result", result, 8'd2);
    @(negedge clk);

    // 16-bit instance without a multiplier.
    run16(3'd7, 16'd3, 16'd5, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run16(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run16(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    run16(3'd5, 16'h8001, 16'd17, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, handshaked successor to the 8-bit combinational add/sub ALU.
- Adds logic, shift and iterative multiply operations on a generic data width.
- Registers the result and all four flags (overflow, unsignedOverflow, isZero, sign) and holds them until the consumer accepts them.
- Sits between the CPU decode stage and writeback; multiply stalls the issuer through the ready/valid handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2 and a power of two.
- MUL_EN, 1, 1 = multiply implemented; 0 = MUL opcode is illegal.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- resetN  input  1  asynchronous active-low reset.
- startValid  input  1  issuer presents an operation.
- startReady  output  1  block can accept an operation.
- opcode  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- firstArg  input  WIDTH  operand A.
- secondArg  input  WIDTH  operand B; for shifts, amount = secondArg[log2(WIDTH)-1:0].
- resultValid  output  1  result and flags are valid.
- resultReady  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- overflow  output  1  signed overflow.
- unsignedOverflow  output  1  carry out / borrow / high half non-zero.
- isZero  output  1  result == 0.
- sign  output  1  result[WIDTH-1].

Behaviour:
- State machine: IDLE, BUSY, DONE.
- Reset (async, resetN=0):
  - state=IDLE.
  - startReady=1 once out of reset (it is derived from the state).
  - resultValid=0; result, all flags and internal operand/counter registers = 0.
- Handshakes:
  - Accept when startValid && startReady; startReady = (state==IDLE), purely state-derived.
  - Output handshake completes on resultValid && resultReady.
- IDLE, on accept:
  - Capture opcode and operands. Later changes to the inputs have no effect on the in-flight operation.
  - Non-MUL ops: compute and register, go to DONE next cycle. Latency is 1 cycle.
  - MUL with MUL_EN=1: go to BUSY with counter = WIDTH.
  - MUL with MUL_EN=0: go to DONE with result=0, isZero=1, other flags 0.
- BUSY:
  - One shift-add step per cycle, 2·WIDTH-bit product accumulator.
  - Counter decrements each step; at counter==1 the final step registers the outputs and the block goes to DONE.
  - resultValid rises exactly WIDTH cycles after the accept edge.
- DONE:
  - resultValid=1; result and flags held stable while resultReady=0.
  - On resultReady: go to IDLE, resultValid=0 next cycle.
  - Minimum issue interval is 2 cycles for single-cycle ops.
- Arithmetic rules:
  - ADD: result = (A+B) mod 2^WIDTH; unsignedOverflow = carry out; overflow = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
  - SUB: result = (A−B) mod 2^WIDTH; unsignedOverflow = borrow (A<B unsigned); overflow = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
  - AND/OR/XOR: overflow=unsignedOverflow=0.
  - SHL/SHR are logical shifts by amount mod WIDTH. unsignedOverflow = any 1 bit shifted out; overflow=0. Shift amount 0 passes A through with flags 0.
  - MUL is unsigned. result = low WIDTH bits of the product; unsignedOverflow = overflow = (high WIDTH bits != 0).
  - isZero and sign are always derived from the registered result.
- Boundary conditions:
  - resetN asserted in BUSY or DONE: abort immediately, outputs cleared, and the pending result is lost.
  - startValid while not IDLE: ignored; the issuer must hold it until accepted.
  - A multiply by 0 still takes the full WIDTH cycles; there is no early termination.
  - Counter wraps are impossible; the counter is sized to log2(WIDTH)+1 bits.

Decomposition:
- Shared package alu_pkg:
  - opcode enum (OP_ADD..OP_MUL).
  - alu_state enum (IDLE, BUSY, DONE).
  - packed flags struct {overflow, unsignedOverflow, isZero, sign}.
- One natural sub-module: iter_multiplier.
  - WIDTH-parametrised shift-add core with start/done, operand registers, counter and 2·WIDTH accumulator.
  - Instantiated only when MUL_EN=1 (generate).

Test Plan (WIDTH=8 unless noted):
- ADD 5+25, resultReady=1 → resultValid 1 cycle after accept, result=30, all flags 0. Then SUB 5−25 → result=0xEC, sign=1, unsignedOverflow=1, overflow=0, isZero=0.
- ADD 0x7F+0x01 → 0x80, overflow=1, sign=1, unsignedOverflow=0. Then ADD 0xFF+0x01 → 0x00, isZero=1, unsignedOverflow=1, overflow=0.
- MUL 0x10×0x10 → resultValid exactly 8 cycles after accept, result=0x00, isZero=1, overflow=unsignedOverflow=1. startReady=0 throughout. Operand changes during BUSY do not alter the result.
- MUL 13×11 with resultReady=0 for 5 cycles after resultValid → result=143 (0x8F), sign=1, flags stable while stalled. startReady stays 0 until the cycle after resultReady=1.
- SHL 0x81 by 1 → 0x02, unsignedOverflow=1. SHR 0x81 by 9 (amount 1) → 0x40, unsignedOverflow=1.
- resetN pulsed low at cycle 3 of a MUL → all outputs 0 immediately, startReady=1 after release. Next ADD 1+1 → 2. Repeat with WIDTH=16, MUL_EN=0: MUL gives result=0, isZero=1 in 1 cycle.
